// File: rtl/inv_multicast_queue.sv
// Invalidation FIFO that broadcasts each head entry to NUM_SINKS sinks and retires it once every sink has taken it.
// Optional macro INV_DRAIN_WAIT_EN adds a DRAIN state that also waits for out_outstanding to clear before retiring.
module inv_multicast_queue #(
  parameter int DEPTH     = 4,
  parameter int NUM_SINKS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [29:0]              in_addr,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     in_completed,
  output logic [29:0]              out_addr,
  output logic [NUM_SINKS-1:0]     out_valid,
  input  logic [NUM_SINKS-1:0]     out_ready,
  input  logic [NUM_SINKS-1:0]     out_outstanding,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

`ifdef INV_DRAIN_WAIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BROADCAST = 2'd1, DRAIN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BROADCAST = 2'd1} state_t;
`endif

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // valid never depends on ready, and once raised it holds with stable data until that transfer.
  logic [29:0]          r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [NUM_SINKS-1:0] r_ack;
  logic                 r_completed;
  state_t               r_state;
  state_t               w_next_state;

  logic [PW-1:0]        w_count;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_head_valid;
  logic                 w_all_acked;
  logic                 w_more;
  logic [NUM_SINKS-1:0] w_hs;

  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign count        = w_count;
  assign in_ready     = (w_count != PW'(DEPTH));
  assign w_push       = in_valid & in_ready;
  assign w_head_valid = (w_count != '0);
  assign out_addr     = r_mem[r_rd_ptr[AW-1:0]];
  assign out_valid    = (w_head_valid && (r_state == BROADCAST)) ? ~r_ack : '0;
  assign w_hs         = out_valid & out_ready;
  assign w_all_acked  = &(r_ack | w_hs);
  // Entries left after popping the head, counting a push landing this same cycle.
  assign w_more       = (w_count > PW'(1)) || w_push;
  assign in_completed = r_completed;
  assign o_dbg_state  = r_state;

`ifdef INV_DRAIN_WAIT_EN
  logic [NUM_SINKS-1:0] r_outstanding;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= out_outstanding;
    end
  end
`else
  logic w_unused_outstanding;
  assign w_unused_outstanding = ^out_outstanding;
`endif

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A push this cycle is visible as head next cycle, so start broadcasting immediately.
        if (w_head_valid || w_push) begin
          w_next_state = BROADCAST;
        end
      end
      BROADCAST: begin
        if (w_head_valid && w_all_acked) begin
`ifdef INV_DRAIN_WAIT_EN
          w_next_state = DRAIN;
`else
          w_pop        = 1'b1;
          w_next_state = w_more ? BROADCAST : IDLE;
`endif
        end else if (!w_head_valid) begin
          w_next_state = IDLE;
        end
      end
`ifdef INV_DRAIN_WAIT_EN
      DRAIN: begin
        if (r_outstanding == '0) begin
          w_pop        = 1'b1;
          w_next_state = w_more ? BROADCAST : IDLE;
        end
      end
`endif
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ack       <= '0;
      r_completed <= 1'b0;
      r_state     <= IDLE;
    end else begin
      r_state     <= w_next_state;
      r_completed <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_ack    <= '0;
      end else begin
        r_ack    <= r_ack | w_hs;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= in_addr;
    end
  end

endmodule
